// File: rtl/hwpe_stream_source_realign_cmd_if.sv
// ============================================================================
// Module      : hwpe_stream_intf_stream
// Description : HWPE-Stream handshake bundle (valid/ready/data/strb).
//               The producer drives valid, data and strb; the consumer
//               drives ready.
// Ports       : none (signal bundle only)
//               master/source : producer side view
//               slave/sink    : consumer side view
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);
  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);

endinterface

`default_nettype wire

// File: rtl/hwpe_stream_source_realign_cmd.sv
// ============================================================================
// Module      : hwpe_stream_source_realign_cmd
// Description : Command-driven source-side realigner for HWPE-Streams.
//               Each queued line command (byte offset, word count, tail
//               byte count) turns a run of misaligned memory words into
//               aligned output words, with a tail strobe on the last word
//               of the line. Commands sit in a small FIFO so address
//               generation is decoupled from the data path.
// Ports       : clk_i, rst_ni (async, active-low), clear_i (sync clear)
//               cmd_valid_i/cmd_ready_o/cmd_offset_i/cmd_len_i/cmd_tail_i
//                 line command write port
//               push_i      : memory words in (strb ignored)
//               pop_o       : realigned words out
//               busy_o      : FSM active or commands pending
//               line_done_o : one-cycle pulse per retired command
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_stream_source_realign_cmd #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CMD_FIFO_DEPTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 cmd_valid_i,
  output logic                                 cmd_ready_o,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]      cmd_offset_i,
  input  logic [15:0]                          cmd_len_i,
  input  logic [$clog2(DATA_WIDTH/8):0]        cmd_tail_i,
  hwpe_stream_intf_stream.slave                push_i,
  hwpe_stream_intf_stream.master               pop_o,
  output logic                                 busy_o,
  output logic                                 line_done_o
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(NB);
  localparam int unsigned TAIL_W = OFF_W + 1;
  localparam int unsigned PTR_W  = $clog2(CMD_FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SH_W   = $clog2(2 * DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [OFF_W-1:0]  off_mem  [CMD_FIFO_DEPTH];
  logic [15:0]       len_mem  [CMD_FIFO_DEPTH];
  logic [TAIL_W-1:0] tail_mem [CMD_FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count_q;
  logic              fifo_full;
  logic              cmd_push;
  logic              retire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CMD_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // No bypass: a full FIFO refuses a write even if the head retires now.
  assign fifo_full   = (count_q == CNT_W'(CMD_FIFO_DEPTH));
  assign cmd_ready_o = ~fifo_full;
  assign cmd_push    = cmd_valid_i & ~fifo_full;
  assign rd_ptr_nxt  = ptr_inc(rd_ptr_q);

  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      off_mem[wr_ptr_q]  <= cmd_offset_i;
      len_mem[wr_ptr_q]  <= cmd_len_i;
      tail_mem[wr_ptr_q] <= cmd_tail_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (cmd_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (retire)   rd_ptr_q <= rd_ptr_nxt;
      case ({cmd_push, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head command drives the active line; the following entry is looked at
  // when a line retires so the next line can start without a bubble.
  logic [OFF_W-1:0]  head_off;
  logic [15:0]       head_len;
  logic [TAIL_W-1:0] head_tail;
  logic [OFF_W-1:0]  nxt_off;
  logic [15:0]       nxt_len;

  assign head_off  = off_mem[rd_ptr_q];
  assign head_len  = len_mem[rd_ptr_q];
  assign head_tail = tail_mem[rd_ptr_q];
  assign nxt_off   = off_mem[rd_ptr_nxt];
  assign nxt_len   = len_mem[rd_ptr_nxt];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic [15:0]       out_cnt_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic              line_done_q;

  logic              cnt_clr;
  logic              cnt_inc;
  logic              prev_ld;
  logic              push_ready;
  logic              pop_valid;
  logic              last_word;

  assign last_word = (state_q == STREAM) && (out_cnt_q == head_len - 16'd1);

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    prev_ld    = 1'b0;
    push_ready = 1'b0;
    pop_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          if (head_len == 16'd0) begin
            retire = 1'b1;
          end else begin
            cnt_clr = 1'b1;
            state_d = (head_off == '0) ? STREAM : PRIME;
          end
        end
      end
      PRIME: begin
        push_ready = 1'b1;
        if (push_i.valid) begin
          prev_ld = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        pop_valid  = push_i.valid;
        push_ready = pop_o.ready;
        if (push_i.valid && pop_o.ready) begin
          prev_ld = 1'b1;
          cnt_inc = 1'b1;
          if (last_word) begin
            retire  = 1'b1;
            cnt_clr = 1'b1;
            // A zero-length follower is retired from IDLE next cycle, so
            // only one command ever leaves the FIFO per clock.
            if (count_q > CNT_W'(1)) begin
              if (nxt_len == 16'd0) state_d = IDLE;
              else                  state_d = (nxt_off == '0) ? STREAM : PRIME;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over any handshake in the same cycle.
    if (clear_i) begin
      push_ready = 1'b0;
      pop_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      out_cnt_q   <= '0;
      prev_q      <= '0;
      line_done_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      out_cnt_q   <= '0;
      prev_q      <= '0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_done_q <= retire;
      if (cnt_clr)      out_cnt_q <= '0;
      else if (cnt_inc) out_cnt_q <= out_cnt_q + 16'd1;
      if (prev_ld)      prev_q    <= push_i.data;
    end
  end

  // --------------------------------------------------------------------------
  // Data path: realign, strobe, mask
  // --------------------------------------------------------------------------
  logic [SH_W-1:0]       rsh;
  logic [SH_W-1:0]       lsh;
  logic [DATA_WIDTH-1:0] realigned;
  logic [TAIL_W-1:0]     tail_eff;
  logic [NB-1:0]         strb;
  logic [DATA_WIDTH-1:0] masked;

  // Low bytes come from the previous word's upper part, high bytes from the
  // current word's lower part. Offset 0 is a plain pass-through.
  assign rsh       = SH_W'({head_off, 3'b000});
  assign lsh       = SH_W'(DATA_WIDTH) - rsh;
  assign realigned = (head_off == '0) ? push_i.data
                                      : ((push_i.data << lsh) | (prev_q >> rsh));
  assign tail_eff  = (head_tail == '0) ? TAIL_W'(NB) : head_tail;

  always_comb begin
    strb   = '1;
    masked = '0;
    if (last_word) begin
      for (int b = 0; b < NB; b++) begin
        strb[b] = (TAIL_W'(b) < tail_eff);
      end
    end
    for (int b = 0; b < NB; b++) begin
      masked[8*b +: 8] = strb[b] ? realigned[8*b +: 8] : 8'h00;
    end
  end

  assign push_i.ready = push_ready;
  assign pop_o.valid  = pop_valid;
  assign pop_o.data   = (state_q == STREAM) ? masked : '0;
  assign pop_o.strb   = strb;

  assign busy_o      = (state_q != IDLE) || (count_q != '0);
  assign line_done_o = line_done_q;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_source_realign_cmd.sv
// ============================================================================
// Module      : tb_hwpe_stream_source_realign_cmd
// Description : Self-checking bench for hwpe_stream_source_realign_cmd.
//               Fixed vectors with hand-computed results, plus random
//               lines checked against a byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hwpe_stream_source_realign_cmd;

  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_offset;
  logic [15:0] cmd_len;
  logic [2:0]  cmd_tail;
  logic        busy;
  logic        line_done;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();

  always #5 clk = ~clk;

  hwpe_stream_source_realign_cmd #(
    .DATA_WIDTH     (DW),
    .CMD_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_offset_i (cmd_offset),
    .cmd_len_i    (cmd_len),
    .cmd_tail_i   (cmd_tail),
    .push_i       (push_if),
    .pop_o        (pop_if),
    .busy_o       (busy),
    .line_done_o  (line_done)
  );

  typedef struct packed {
    logic [1:0]  off;
    logic [15:0] len;
    logic [2:0]  tail;
  } cmd_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
  } out_t;

  typedef struct packed {
    logic [1:0]       off;
    logic [15:0]      len;
    logic [2:0]       tail;
    logic [1:0]       n_in;
    logic [2:0][31:0] din;
    logic [2:0][31:0] dout;
    logic [2:0][3:0]  strb;
  } vec_t;

  cmd_t        cmdq [$];
  logic [31:0] dq   [$];
  out_t        expq [$];

  int total = 0;
  int bad   = 0;
  int consumed, exp_in, done_cnt, exp_done, gaps, pop_cnt, acc_cnt;
  bit seen_pop, full_mode;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int off, input int len, input int tail, input int n_in,
                              input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                              input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                              input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2);
    vec_t v;
    v.off  = 2'(off);
    v.len  = 16'(len);
    v.tail = 3'(tail);
    v.n_in = 2'(n_in);
    v.din  = {i2, i1, i0};
    v.dout = {o2, o1, o0};
    v.strb = {s2, s1, s0};
    return v;
  endfunction

  task automatic reset_counts();
    consumed = 0; exp_in = 0; done_cnt = 0; exp_done = 0;
    gaps = 0; pop_cnt = 0; acc_cnt = 0; seen_pop = 0; full_mode = 0;
  endtask

  // Reference model: the line is a window into the byte stream of the words
  // it consumes, starting at the offset; the last word keeps only tail bytes.
  task automatic add_line(input int o, input int len, input int t);
    logic [7:0]  bytes [$];
    logic [31:0] w;
    out_t        e;
    int          nin, te;
    nin = (len == 0) ? 0 : len + ((o != 0) ? 1 : 0);
    for (int i = 0; i < nin; i++) begin
      w = $urandom;
      dq.push_back(w);
      for (int j = 0; j < NB; j++) bytes.push_back(w[8*j +: 8]);
    end
    te = (t == 0) ? NB : t;
    for (int k = 0; k < len; k++) begin
      e = '0;
      for (int j = 0; j < NB; j++) begin
        if (k == len - 1 && j >= te) begin
          e.d[8*j +: 8] = 8'h00;
          e.s[j]        = 1'b0;
        end else begin
          e.d[8*j +: 8] = bytes[o + k*NB + j];
          e.s[j]        = 1'b1;
        end
      end
      expq.push_back(e);
    end
    cmdq.push_back({2'(o), 16'(len), 3'(t)});
    exp_done++;
    exp_in += nin;
  endtask

  task automatic add_vec(input vec_t v);
    out_t e;
    for (int i = 0; i < int'(v.n_in); i++) dq.push_back(v.din[i]);
    for (int k = 0; k < int'(v.len); k++) begin
      e.d = v.dout[k];
      e.s = v.strb[k];
      expq.push_back(e);
    end
    cmdq.push_back({v.off, v.len, v.tail});
    exp_done++;
    exp_in += int'(v.n_in);
  endtask

  // One clock: drive after the edge, sample at the falling edge.
  task automatic step(input bit rnd_rdy, input bit rnd_vld, input bit hold_data);
    out_t e;
    @(posedge clk);
    #1;
    cmd_valid = (cmdq.size() > 0);
    if (cmdq.size() > 0) begin
      cmd_offset = cmdq[0].off;
      cmd_len    = cmdq[0].len;
      cmd_tail   = cmdq[0].tail;
    end
    push_if.valid = !hold_data && (dq.size() > 0) && (!rnd_vld || $urandom_range(3) != 0);
    push_if.data  = (dq.size() > 0) ? dq[0] : 32'hDEADBEEF;
    push_if.strb  = '1;
    pop_if.ready  = !rnd_rdy || ($urandom_range(1) == 1);
    @(negedge clk);
    if (line_done) done_cnt++;
    if (cmd_valid && cmd_ready) begin
      if (full_mode && acc_cnt == DEPTH) check("cmd5_after_retire", 64'(done_cnt > 0), 64'd1);
      void'(cmdq.pop_front());
      acc_cnt++;
    end
    if (push_if.valid && push_if.ready) begin
      void'(dq.pop_front());
      consumed++;
    end
    if (pop_if.valid && pop_if.ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_pop: got %h expected no output", pop_if.data);
      end else begin
        e = expq.pop_front();
        check("pop_data", 64'(pop_if.data), 64'(e.d));
        check("pop_strb", 64'(pop_if.strb), 64'(e.s));
      end
      seen_pop = 1;
      pop_cnt++;
    end else if (seen_pop && expq.size() > 0) begin
      gaps++;
    end
  endtask

  task automatic run(input string name, input bit rnd_rdy, input bit rnd_vld, input int budget);
    int cyc;
    cyc = 0;
    while (!(cmdq.size() == 0 && expq.size() == 0 && dq.size() == 0 && !busy)) begin
      if (cyc >= budget) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: got %0d cycles expected completion", name, cyc);
        break;
      end
      step(rnd_rdy, rnd_vld, 1'b0);
      cyc++;
    end
    check({name, "_line_done"}, 64'(done_cnt), 64'(exp_done));
    check({name, "_consumed"}, 64'(consumed), 64'(exp_in));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; cmd_valid = 1'b0;
    cmd_offset = '0; cmd_len = '0; cmd_tail = '0;
    push_if.valid = 1'b0; push_if.data = '0; push_if.strb = '1;
    pop_if.ready = 1'b0;
    reset_counts();

    vecs[0] = mk(0, 3, 0, 3, 32'hA00000A0, 32'hA10000A1, 32'hA20000A2,
                 32'hA00000A0, 32'hA10000A1, 32'hA20000A2, 4'hF, 4'hF, 4'hF);
    vecs[1] = mk(1, 2, 0, 3, 32'h33221100, 32'h77665544, 32'hBBAA9988,
                 32'h44332211, 32'h88776655, 32'h0, 4'hF, 4'hF, 4'h0);
    vecs[2] = mk(1, 2, 3, 3, 32'h33221100, 32'h77665544, 32'hBBAA9988,
                 32'h44332211, 32'h00776655, 32'h0, 4'hF, 4'h7, 4'h0);
    vecs[3] = mk(3, 2, 1, 3, 32'h33221100, 32'h77665544, 32'hBBAA9988,
                 32'h66554433, 32'h00000077, 32'h0, 4'hF, 4'h1, 4'h0);
    vecs[4] = mk(2, 1, 2, 2, 32'h33221100, 32'h77665544, 32'h0,
                 32'h00003322, 32'h0, 32'h0, 4'h3, 4'h0, 4'h0);
    vecs[5] = mk(0, 1, 4, 1, 32'hCAFEF00D, 32'h0, 32'h0,
                 32'hCAFEF00D, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_pop_valid", 64'(pop_if.valid), 64'd0);
    check("rst_pop_data", 64'(pop_if.data), 64'd0);
    check("rst_pop_strb", 64'(pop_if.strb), 64'hF);
    check("rst_push_ready", 64'(push_if.ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_line_done", 64'(line_done), 64'd0);

    // Fixed vectors
    for (int i = 0; i < 6; i++) begin
      reset_counts();
      add_vec(vecs[i]);
      run("vec", 1'b0, 1'b0, 100);
    end

    // FIFO full, then back-to-back aligned lines with no bubble
    reset_counts();
    for (int i = 0; i < 5; i++) add_line(0, 3, 0);
    full_mode = 1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    check("full_accepted", 64'(acc_cnt), 64'd4);
    check("full_cmd_ready", 64'(cmd_ready), 64'd0);
    run("b2b", 1'b0, 1'b0, 200);
    check("b2b_gaps", 64'(gaps), 64'd0);

    // Zero-length command between lines
    reset_counts();
    add_line(2, 2, 1);
    add_line(0, 0, 0);
    add_line(3, 2, 0);
    run("len0", 1'b1, 1'b0, 200);

    // Backpressure over a long misaligned line
    reset_counts();
    add_line(1, 16, 0);
    run("bp", 1'b1, 1'b1, 400);

    // Random lines
    reset_counts();
    for (int i = 0; i < 10; i++)
      add_line(int'($urandom_range(3)), int'($urandom_range(6)), int'($urandom_range(4)));
    run("rand", 1'b1, 1'b1, 1000);

    // Clear mid-line with two commands queued
    reset_counts();
    add_line(1, 5, 0);
    add_line(0, 3, 0);
    for (int i = 0; i < 50 && pop_cnt < 2; i++) step(1'b0, 1'b0, 1'b0);
    check("clr_pops_before", 64'(pop_cnt), 64'd2);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    cmd_valid = 1'b0;
    push_if.valid = 1'b0;
    @(negedge clk);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_pop_valid", 64'(pop_if.valid), 64'd0);
    check("clr_cmd_ready", 64'(cmd_ready), 64'd1);
    check("clr_line_done", 64'(line_done), 64'd0);
    cmdq.delete();
    dq.delete();
    expq.delete();
    reset_counts();
    add_line(0, 3, 2);
    run("after_clr", 1'b0, 1'b0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
